// File: rtl/mem_stage_pkg.sv
// Shared types and address-split constants for the MEM-stage data cache.
package mem_stage_pkg;

    localparam int BASE_ADDR = 1024;
    localparam int WADDR_W   = 16;
    localparam int LINES     = 64;
    localparam int IDX_W     = 6;
    localparam int TAG_W     = WADDR_W - IDX_W;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR      = 2'd2
    } state_t;

endpackage

// File: rtl/cache_dm_array.sv
// Direct-mapped line storage: one word per line, combinational lookup, single write port.
module cache_dm_array
    import mem_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag,
    output logic             hit,
    output logic [31:0]      rdata,
    input  logic             we,
    input  logic [31:0]      wdata
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[index] <= 1'b1;
        end
    end

    // Tag and data need no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= wdata;
        end
    end

    assign hit   = valid[index] && (tag_mem[index] == tag);
    assign rdata = data_mem[index];

endmodule

// File: rtl/mem_stage_cache.sv
// Write-through, no-write-allocate, direct-mapped data cache between the MEM stage and a multi-cycle SRAM.
//   state   | meaning
//   IDLE    | evaluate the current instruction; read hits complete here
//   RD_MISS | waiting for SRAM read data to fill the line
//   WR      | waiting for SRAM to accept a store
module mem_stage_cache
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               cache_freeze,
    output logic               sram_req,
    output logic               sram_we,
    output logic [WADDR_W-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    input  logic               sram_ready,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    state_t             state;
    logic [31:0]        offset;
    logic [WADDR_W-1:0] waddr;
    logic               unused_offset_bits;
    logic               arr_hit;
    logic [31:0]        arr_rdata;
    logic               arr_we;
    logic [31:0]        arr_wdata;

    assign offset             = addr - 32'(BASE_ADDR);
    assign waddr              = offset[WADDR_W+1:2];
    assign unused_offset_bits = ^{offset[31:WADDR_W+2], offset[1:0]};

    assign sram_addr  = waddr;
    assign sram_wdata = wdata;

    cache_dm_array u_array (
        .clk   (clk),
        .rst   (rst),
        .index (waddr[IDX_W-1:0]),
        .tag   (waddr[WADDR_W-1:IDX_W]),
        .hit   (arr_hit),
        .rdata (arr_rdata),
        .we    (arr_we),
        .wdata (arr_wdata)
    );

    // Freeze and request must respond in the same cycle the instruction arrives.
    always_comb begin
        cache_freeze = 1'b0;
        sram_req     = 1'b0;
        sram_we      = 1'b0;
        rdata        = '0;
        arr_we       = 1'b0;
        arr_wdata    = wdata;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (MEM_W_EN) begin
                        sram_req     = 1'b1;
                        sram_we      = 1'b1;
                        cache_freeze = 1'b1;
                    end else if (MEM_R_EN) begin
                        if (arr_hit) begin
                            rdata = arr_rdata;
                        end else begin
                            sram_req     = 1'b1;
                            cache_freeze = 1'b1;
                        end
                    end
                end
                RD_MISS: begin
                    sram_req     = 1'b1;
                    cache_freeze = !sram_ready;
                    if (sram_ready) begin
                        rdata     = sram_rdata;
                        arr_we    = 1'b1;
                        arr_wdata = sram_rdata;
                    end
                end
                WR: begin
                    sram_req     = 1'b1;
                    sram_we      = 1'b1;
                    cache_freeze = !sram_ready;
                    arr_we       = sram_ready && arr_hit;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_W_EN) begin
                        state <= WR;
                    end else if (MEM_R_EN) begin
                        if (arr_hit) begin
                            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                        end else begin
                            state <= RD_MISS;
                            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                        end
                    end
                end
                RD_MISS, WR: begin
                    if (sram_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_cache.sv
// Directed plus randomized bench for mem_stage_cache against a line-level cache/memory model.
module tb_mem_stage_cache;

    localparam logic [31:0] INIT_WORD0 = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] addr, wdata, rdata;
    logic        cache_freeze, sram_req, sram_we, sram_ready;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [15:0] hit_count, miss_count;

    int n_checks = 0;
    int n_pass   = 0;
    int sram_lat = 1;

    always #5 clk = ~clk;

    mem_stage_cache dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .cache_freeze (cache_freeze),
        .sram_req     (sram_req),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    // SRAM model: ready pulses sram_lat cycles after req first rises.
    logic [31:0] sram_mem [int];
    bit          busy;
    int          cnt;

    function automatic logic [31:0] mem_rd(input int a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return (a == 0) ? INIT_WORD0 : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            cnt        <= 0;
            sram_ready <= 1'b0;
            sram_rdata <= '0;
        end else if (sram_ready) begin
            if (sram_we) sram_mem[int'(sram_addr)] = sram_wdata;
            busy       <= 1'b0;
            sram_ready <= 1'b0;
            sram_rdata <= '0;
        end else if (!busy) begin
            if (sram_req) begin
                busy <= 1'b1;
                cnt  <= sram_lat - 1;
                if (sram_lat == 1) begin
                    sram_ready <= 1'b1;
                    sram_rdata <= mem_rd(int'(sram_addr));
                end
            end
        end else begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                sram_ready <= 1'b1;
                sram_rdata <= mem_rd(int'(sram_addr));
            end
        end
    end

    // Reference model: what a direct-mapped write-through cache should hold.
    bit          ref_valid [64];
    int          ref_tag   [64];
    logic [31:0] ref_data  [64];
    logic [31:0] ref_mem   [int];
    int          ref_hits, ref_misses;

    function automatic logic [31:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return (a == 0) ? INIT_WORD0 : 32'h0;
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Entered just after a rising edge; returns just after the edge that completes the op.
    task automatic run_op(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int lat);
        logic [31:0] off;
        int          wa, idx, tg, stalls;
        bit          done;
        logic [31:0] exp;
        off = a - 32'd1024;
        wa  = int'(off[17:2]);
        idx = wa % 64;
        tg  = wa / 64;
        sram_lat = lat;
        MEM_R_EN = rd;
        MEM_W_EN = wr;
        addr     = a;
        wdata    = d;
        if (!rd && !wr) begin
            @(negedge clk);
            check("nop_freeze", 32'(cache_freeze), 32'h0);
            check("nop_rdata", rdata, 32'h0);
            check("nop_req", 32'(sram_req), 32'h0);
            @(posedge clk); #1;
        end else if (rd && !wr && ref_valid[idx] && ref_tag[idx] == tg) begin
            @(negedge clk);
            check("hit_freeze", 32'(cache_freeze), 32'h0);
            check("hit_rdata", rdata, ref_data[idx]);
            @(posedge clk); #1;
            if (ref_hits < 65535) ref_hits++;
        end else begin
            exp    = ref_rd(wa);
            stalls = 0;
            done   = 1'b0;
            for (int k = 0; k < 40 && !done; k++) begin
                @(negedge clk);
                if (k == 0) check("sram_addr", 32'(sram_addr), 32'(wa));
                check("sram_req", 32'(sram_req), 32'h1);
                check("sram_we", 32'(sram_we), 32'(wr));
                if (cache_freeze) begin
                    stalls++;
                end else begin
                    done = 1'b1;
                    check(wr ? "store_rdata" : "miss_rdata", rdata, wr ? 32'h0 : exp);
                end
                @(posedge clk); #1;
            end
            check("completed", 32'(done), 32'h1);
            check("stall_cycles", 32'(stalls), 32'(lat));
            if (wr) begin
                ref_mem[wa] = d;
                if (ref_valid[idx] && ref_tag[idx] == tg) ref_data[idx] = d;
            end else begin
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
                ref_data[idx]  = exp;
                if (ref_misses < 65535) ref_misses++;
            end
        end
        check("hit_count", 32'(hit_count), 32'(ref_hits));
        check("miss_count", 32'(miss_count), 32'(ref_misses));
    endtask

    initial begin
        int m0;
        rst      = 1'b1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        addr     = '0;
        wdata    = '0;
        ref_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_freeze", 32'(cache_freeze), 32'h0);
        check("rst_req", 32'(sram_req), 32'h0);
        check("rst_we", 32'(sram_we), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_hits", 32'(hit_count), 32'h0);
        check("rst_misses", 32'(miss_count), 32'h0);
        @(posedge clk); #1;

        // Cold miss then hit on word 0.
        run_op(1, 0, 32'd1024, 32'h0, 3);
        run_op(1, 0, 32'd1024, 32'h0, 3);
        // Store-hit updates the line and SRAM.
        run_op(0, 1, 32'd1024, 32'h12345678, 2);
        check("sram_word0", mem_rd(0), 32'h12345678);
        run_op(1, 0, 32'd1024, 32'h0, 1);
        // Store-miss must not allocate.
        run_op(0, 1, 32'd1028, 32'hCAFEF00D, 2);
        check("sram_word1", mem_rd(1), 32'hCAFEF00D);
        m0 = int'(miss_count);
        run_op(1, 0, 32'd1028, 32'h0, 1);
        check("no_allocate", 32'(int'(miss_count) - m0), 32'h1);
        // Conflict eviction at index 0.
        m0 = int'(miss_count);
        run_op(1, 0, 32'd1280, 32'h0, 2);
        run_op(1, 0, 32'd1024, 32'h0, 2);
        run_op(1, 0, 32'd1280, 32'h0, 1);
        check("conflict_misses", 32'(int'(miss_count) - m0), 32'h3);

        // Reset while a read miss is outstanding.
        sram_lat = 4;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        addr     = 32'd1032;
        @(negedge clk);
        check("pre_rst_freeze", 32'(cache_freeze), 32'h1);
        @(posedge clk); #1;
        rst      = 1'b1;
        MEM_R_EN = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_reset();
        @(negedge clk);
        check("midrst_req", 32'(sram_req), 32'h0);
        check("midrst_freeze", 32'(cache_freeze), 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_hits", 32'(hit_count), 32'h0);
        check("midrst_misses", 32'(miss_count), 32'h0);
        @(posedge clk); #1;
        run_op(1, 0, 32'd1024, 32'h0, 2);

        // Read and write together act as a store.
        run_op(1, 1, 32'd1032, 32'hA5A5A5A5, 3);
        check("sram_word2", mem_rd(2), 32'hA5A5A5A5);

        // Randomized back-to-back traffic over a few conflicting lines.
        for (int i = 0; i < 200; i++) begin
            int          r;
            bit          rd, wr;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            rd = (r < 6) || (r == 8);
            wr = (r == 6) || (r == 7) || (r == 8);
            a  = 32'd1024 + 32'(4 * $urandom_range(0, 3)) + 32'(256 * $urandom_range(0, 1));
            run_op(rd, wr, a, $urandom, int'($urandom_range(1, 4)));
        end

        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_cache.md
Name: mem_stage_cache

Overview:
- MEM-stage data cache controller, directly downstream of the EXE/MEM pipeline register.
- Consumes ALU_result (address), val_Rm (store data), MEM_R_EN and MEM_W_EN.
- Serves loads from a direct-mapped, write-through, no-write-allocate cache in front of a multi-cycle SRAM.
- Drives cache_freeze, which stalls the whole pipeline, including the EXE/MEM register, while SRAM is busy.

Parameters:
- BASE_ADDR, 1024: data-memory base; word address = (addr - BASE_ADDR) >> 2.
- WADDR_W, 16: SRAM word-address width.
- LINES, 64: cache lines, one 32-bit word per line, power of 2.
- IDX_W, 6: log2(LINES).
- TAG_W, 10: WADDR_W - IDX_W.
- CNT_W, 16: width of the hit and miss counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- addr  in  32  byte address (ALU_result)
- wdata  in  32  store data (val_Rm)
- rdata  out  32  load data to MEM/WB
- cache_freeze  out  1  pipeline stall
- sram_req  out  1  SRAM request, held until sram_ready
- sram_we  out  1  1 = write, 0 = read
- sram_addr  out  WADDR_W  SRAM word address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid with sram_ready
- sram_ready  in  1  one-cycle completion pulse
- hit_count  out  CNT_W  saturating read-hit counter
- miss_count  out  CNT_W  saturating read-miss counter

Behaviour:
- Address split: waddr = (addr - BASE_ADDR)[WADDR_W+1:2]; index = waddr[IDX_W-1:0]; tag = waddr[WADDR_W-1:IDX_W]. Unused upper bits are ignored.
- Arrays: valid[LINES] is reset to 0. tag[] and data[] are not reset.
- Request priority: MEM_W_EN=1 takes priority; simultaneous MEM_R_EN=1 and MEM_W_EN=1 is treated as a store only. Neither asserted means no operation: cache_freeze=0 and rdata=0.
- FSM states:
  - IDLE, with two exits:
    - read hit: rdata = data[index] combinationally, cache_freeze=0, state stays IDLE, hit_count+1.
    - read miss or store: sram_req=1, cache_freeze=1 in the same cycle; next state RD_MISS (miss_count+1) or WR.
  - RD_MISS: sram_req=1, sram_we=0.
    - While sram_ready=0: cache_freeze=1.
    - Cycle with sram_ready=1: rdata = sram_rdata and cache_freeze=0 in that cycle. At the edge, write data/tag[index], set valid[index]=1, go to IDLE.
  - WR: sram_req=1, sram_we=1, sram_wdata=wdata.
    - While sram_ready=0: cache_freeze=1.
    - Cycle with sram_ready=1: cache_freeze=0. At the edge, if the line hits, update data[index] to wdata; on a miss, leave the cache unchanged (no allocate). Go to IDLE.
- sram_addr = waddr at all times.
- Inputs are stable while cache_freeze=1 because upstream is frozen. Changing them mid-transaction is illegal.
- SRAM contract: sram_ready asserts no earlier than 1 cycle after sram_req first rises.
- Latencies:
  - Read hit adds 0 stall cycles.
  - Read miss and store each stall for exactly N cycles, where N is the SRAM latency measured from req rise to the ready pulse.
- Back-to-back operations: after returning to IDLE, the next instruction is evaluated in the following cycle. No idle bubble is inserted by the controller.
- Eviction: a miss fill overwrites whatever line sits at that index.
- Counters: saturate at all-ones and never wrap.
- Reset, including mid-transaction:
  - state → IDLE
  - all valid bits cleared
  - sram_req=0, sram_we=0, cache_freeze=0, rdata=0
  - hit_count=0, miss_count=0
  - The SRAM model must also reset; an in-flight transaction is abandoned.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum {IDLE, RD_MISS, WR}
  - BASE_ADDR
  - the address-split widths
- One natural sub-module, cache_dm_array: the valid/tag/data storage with a combinational read port and one synchronous write port. It reports hit and rdata for a given index/tag.

Test Plan:
1. Load from 1024 after reset with SRAM latency 3 and SRAM word0=0xDEADBEEF → cache_freeze high for 3 cycles, rdata=0xDEADBEEF in the ready cycle, miss_count=1. Repeat load → no freeze, same data, hit_count=1.
2. After (1), store 0x12345678 to 1024 with latency 2 → freeze for 2 cycles, SRAM written. Next load from 1024 → hit, returns 0x12345678.
3. Store to 1028, never loaded before → SRAM written. Subsequent load from 1028 misses (miss_count increments), proving no-allocate.
4. Load 1024, then load 1024+LINES*4=1280, then load 1024 → three misses: conflict eviction on the shared index.
5. Assert rst during RD_MISS before sram_ready → next cycle: IDLE, sram_req=0, cache_freeze=0, counters 0. Load from 1024 misses again.
6. MEM_R_EN=1 and MEM_W_EN=1 at 1032 with data 0xA5A5A5A5 → SRAM write issued (sram_we=1), miss_count unchanged, rdata=0.
